// File: rtl/mem_stage_ctrl_if.sv
// Bus bundle between the MEM-stage controller, the EX/MEM register,
// the data memory and the pipeline stall/writeback consumers.
interface mem_stage_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // EX/MEM side
   logic              start_i;
   logic              MemRead_i;
   logic              MemWrite_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i;
   // data memory side
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;
   // pipeline control / MEM/WB side
   logic              stall_o;
   logic [DATA_W-1:0] rdata_o;
   logic              rdata_valid_o;
   logic              misalign_o;
   logic              timeout_o;

   // pipeline + memory: drives requests and acks, observes the controller
   modport master (
      output start_i, MemRead_i, MemWrite_i, addr_i, wdata_i,
      output mem_ack_i, mem_rdata_i,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  stall_o, rdata_o, rdata_valid_o, misalign_o, timeout_o
   );

   // controller
   modport slave (
      input  start_i, MemRead_i, MemWrite_i, addr_i, wdata_i,
      input  mem_ack_i, mem_rdata_i,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output stall_o, rdata_o, rdata_valid_o, misalign_o, timeout_o
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: turns EX/MEM load/store controls into a
// req/ack memory transaction, stalls the pipeline while it is in flight,
// registers load data for MEM/WB and flags misaligned or timed-out accesses.
module mem_stage_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input logic             clk_i,
   input logic             rst_i,
   mem_stage_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rdata_valid;
   logic              misalign;
   logic              timeout;
   logic              acc;
   logic              aligned;

   assign acc     = bus.start_i & (bus.MemRead_i | bus.MemWrite_i);
   assign aligned = (bus.addr_i[1:0] == 2'b00);

   // Stall is combinational so the pipeline freezes in the cycle the access
   // appears; DONE releases it so the pipeline advances without re-issuing.
   assign bus.stall_o = ~rst_i & (((state == IDLE) & acc & aligned) | (state == ACCESS));

   assign bus.mem_req_o     = req;
   assign bus.mem_we_o      = we;
   assign bus.mem_addr_o    = addr;
   assign bus.mem_wdata_o   = wdata;
   assign bus.rdata_o       = rdata;
   assign bus.rdata_valid_o = rdata_valid;
   assign bus.misalign_o    = misalign;
   assign bus.timeout_o     = timeout;

   // Access FSM with registered memory-side and status outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         req         <= 1'b0;
         we          <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         misalign    <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         misalign    <= 1'b0;
         timeout     <= 1'b0;
         case (state)
            IDLE: begin
               if (acc) begin
                  if (aligned) begin
                     addr  <= bus.addr_i;
                     wdata <= bus.wdata_i;
                     we    <= bus.MemWrite_i;
                     cnt   <= '0;
                     req   <= 1'b1;
                     state <= ACCESS;
                  end else begin
                     misalign <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               // ack on the final counted cycle takes priority over the timeout
               if (bus.mem_ack_i) begin
                  req <= 1'b0;
                  if (!we) begin
                     rdata       <= bus.mem_rdata_i;
                     rdata_valid <= 1'b1;
                  end
                  state <= DONE;
               end else if (cnt == CNT_LAST) begin
                  req         <= 1'b0;
                  rdata       <= '0;
                  rdata_valid <= ~we;
                  timeout     <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_stage_ctrl;

   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_stage_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef enum int {EV_ISSUE, EV_REQLEN, EV_STALLLEN, EV_VALID, EV_TIMEOUT, EV_MISALIGN} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic        w;
      logic [31:0] a;
      logic [31:0] b;
   } ev_t;

   ev_t  exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   req_n = 0;
   int   stall_n = 0;
   int   issue_cyc = 0;
   int   done_cyc = 0;
   logic req_q = 1'b0;
   logic stall_q = 1'b0;

   task automatic expect_ev(input ev_kind_t k, input logic w, input logic [31:0] a, input logic [31:0] b);
      ev_t e;
      e.kind = k; e.w = w; e.a = a; e.b = b;
      exp_q.push_back(e);
   endtask

   task automatic got(input ev_kind_t k, input logic w, input logic [31:0] a, input logic [31:0] b);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s act w=%0d a=%h b=%h required none", k.name(), w, a, b);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== k || e.w !== w || e.a !== a || e.b !== b) begin
            errors++;
            $display("FAIL event act %s w=%0d a=%h b=%h required %s w=%0d a=%h b=%h",
                     k.name(), w, a, b, e.kind.name(), e.w, e.a, e.b);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s act=%h required=%h", name, act, req);
      end
   endtask

   // Cycle stamp for latency checks.
   always @(posedge clk) cyc++;

   // Monitor: turns DUT output activity into events and checks them in order.
   always @(negedge clk) begin
      if (bus.mem_req_o && !req_q) begin
         issue_cyc = cyc;
         got(EV_ISSUE, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
      end
      if (bus.mem_req_o) req_n++;
      else if (req_q) begin
         got(EV_REQLEN, 1'b0, 32'(req_n), 32'h0);
         req_n = 0;
      end
      if (bus.stall_o) stall_n++;
      else if (stall_q) begin
         got(EV_STALLLEN, 1'b0, 32'(stall_n), 32'h0);
         stall_n = 0;
      end
      if (bus.rdata_valid_o) got(EV_VALID, 1'b0, bus.rdata_o, 32'h0);
      if (bus.timeout_o)     got(EV_TIMEOUT, 1'b0, 32'h0, 32'h0);
      if (bus.misalign_o)    got(EV_MISALIGN, 1'b0, 32'h0, 32'h0);
      req_q   = bus.mem_req_o;
      stall_q = bus.stall_o;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      bus.start_i    = 1'b1;
      bus.MemRead_i  = rd;
      bus.MemWrite_i = wr;
      bus.addr_i     = a;
      bus.wdata_i    = d;
   endtask

   task automatic clear();
      bus.MemRead_i  = 1'b0;
      bus.MemWrite_i = 1'b0;
      bus.addr_i     = 32'h0;
      bus.wdata_i    = 32'h0;
   endtask

   // From the IDLE accept cycle through to DONE; lat<0 means no ack at all.
   task automatic run(input int lat, input logic [31:0] rd, input bit drop_start);
      tick();
      if (drop_start) bus.start_i = 1'b0;
      for (int c = 0; c < TO; c++) begin
         bus.mem_ack_i   = (c == lat);
         bus.mem_rdata_i = rd;
         tick();
         bus.mem_ack_i = 1'b0;
         if (c == lat) break;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},    32'(bus.mem_req_o), 32'h0);
      chk({tag, "_we"},     32'(bus.mem_we_o), 32'h0);
      chk({tag, "_addr"},   bus.mem_addr_o, 32'h0);
      chk({tag, "_wdata"},  bus.mem_wdata_o, 32'h0);
      chk({tag, "_rdata"},  bus.rdata_o, 32'h0);
      chk({tag, "_valid"},  32'(bus.rdata_valid_o), 32'h0);
      chk({tag, "_mis"},    32'(bus.misalign_o), 32'h0);
      chk({tag, "_to"},     32'(bus.timeout_o), 32'h0);
      chk({tag, "_stall"},  32'(bus.stall_o), 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 32'h0;
      // aligned read presented during reset must not stall
      present(1'b1, 1'b0, 32'h10, 32'h0);
      tick();
      tick();
      chk_all_zero("reset");
      clear();
      rst = 1'b0;
      tick();

      // load, L=2
      expect_ev(EV_ISSUE, 1'b0, 32'h10, 32'h0);
      expect_ev(EV_REQLEN, 1'b0, 32'd3, 32'h0);
      expect_ev(EV_STALLLEN, 1'b0, 32'd4, 32'h0);
      expect_ev(EV_VALID, 1'b0, 32'hCAFEF00D, 32'h0);
      present(1'b1, 1'b0, 32'h10, 32'h0);
      run(2, 32'hCAFEF00D, 1'b0);
      chk("load_rdata", bus.rdata_o, 32'hCAFEF00D);
      clear();
      tick();

      // store, L=0
      expect_ev(EV_ISSUE, 1'b1, 32'h20, 32'h12345678);
      expect_ev(EV_REQLEN, 1'b0, 32'd1, 32'h0);
      expect_ev(EV_STALLLEN, 1'b0, 32'd2, 32'h0);
      present(1'b0, 1'b1, 32'h20, 32'h12345678);
      run(0, 32'hFFFFFFFF, 1'b0);
      chk("store_rdata_kept", bus.rdata_o, 32'hCAFEF00D);
      clear();
      tick();

      // misaligned read
      expect_ev(EV_MISALIGN, 1'b0, 32'h0, 32'h0);
      present(1'b1, 1'b0, 32'h22, 32'h0);
      #1;
      chk("mis_stall", 32'(bus.stall_o), 32'h0);
      tick();
      clear();
      chk("mis_req", 32'(bus.mem_req_o), 32'h0);
      tick();
      chk("mis_rdata_kept", bus.rdata_o, 32'hCAFEF00D);

      // read with no ack: timeout
      expect_ev(EV_ISSUE, 1'b0, 32'h30, 32'h0);
      expect_ev(EV_REQLEN, 1'b0, 32'd16, 32'h0);
      expect_ev(EV_STALLLEN, 1'b0, 32'd17, 32'h0);
      expect_ev(EV_VALID, 1'b0, 32'h0, 32'h0);
      expect_ev(EV_TIMEOUT, 1'b0, 32'h0, 32'h0);
      present(1'b1, 1'b0, 32'h30, 32'h0);
      run(-1, 32'h0, 1'b0);
      chk("to_rdata", bus.rdata_o, 32'h0);
      clear();
      tick();

      // read acked on the 16th ACCESS cycle: ack wins
      expect_ev(EV_ISSUE, 1'b0, 32'h34, 32'h0);
      expect_ev(EV_REQLEN, 1'b0, 32'd16, 32'h0);
      expect_ev(EV_STALLLEN, 1'b0, 32'd17, 32'h0);
      expect_ev(EV_VALID, 1'b0, 32'hA5A55A5A, 32'h0);
      present(1'b1, 1'b0, 32'h34, 32'h0);
      run(15, 32'hA5A55A5A, 1'b0);
      clear();
      tick();

      // reset on 3rd ACCESS cycle of an L=5 read, late ack ignored
      expect_ev(EV_ISSUE, 1'b0, 32'h40, 32'h0);
      expect_ev(EV_STALLLEN, 1'b0, 32'd3, 32'h0);
      expect_ev(EV_REQLEN, 1'b0, 32'd3, 32'h0);
      present(1'b1, 1'b0, 32'h40, 32'h0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rst_stall_forced", 32'(bus.stall_o), 32'h0);
      tick();
      rst = 1'b0;
      clear();
      chk_all_zero("midrst");
      tick();
      tick();
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hBAD0BAD0;
      tick();
      bus.mem_ack_i = 1'b0;
      tick();
      chk("late_ack_rdata", bus.rdata_o, 32'h0);
      chk("late_ack_req", 32'(bus.mem_req_o), 32'h0);

      // back-to-back: load (start dropped in ACCESS) then store presented in DONE
      expect_ev(EV_ISSUE, 1'b0, 32'h0, 32'h0);
      expect_ev(EV_REQLEN, 1'b0, 32'd2, 32'h0);
      expect_ev(EV_STALLLEN, 1'b0, 32'd3, 32'h0);
      expect_ev(EV_VALID, 1'b0, 32'h11112222, 32'h0);
      expect_ev(EV_ISSUE, 1'b1, 32'h4, 32'hDEADBEEF);
      expect_ev(EV_REQLEN, 1'b0, 32'd1, 32'h0);
      expect_ev(EV_STALLLEN, 1'b0, 32'd2, 32'h0);
      present(1'b1, 1'b0, 32'h0, 32'h0);
      run(1, 32'h11112222, 1'b1);
      done_cyc = cyc;
      present(1'b0, 1'b1, 32'h4, 32'hDEADBEEF);
      tick();
      run(0, 32'h0, 1'b0);
      chk("b2b_issue_gap", 32'(issue_cyc - done_cyc), 32'd2);
      chk("b2b_rdata_kept", bus.rdata_o, 32'h11112222);
      clear();
      tick();
      tick();
      tick();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events act=%0d outstanding required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access controller between the EX/MEM pipeline register and a variable-latency data memory. It converts the EX/MEM load/store controls into a req/ack transaction and freezes the pipeline with `stall_o` while the transaction is in flight. It registers load data for the MEM/WB register. Misaligned word accesses and unresponsive memory are detected and reported without hanging the pipeline.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 16, maximum cycles in ACCESS waiting for `mem_ack_i` (≥1)

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  enable; low blocks acceptance of new accesses
- `MemRead_i`  in  1  load request from EX/MEM
- `MemWrite_i`  in  1  store request from EX/MEM
- `addr_i`  in  ADDR_W  byte address (ALU result from EX/MEM)
- `wdata_i`  in  DATA_W  store data from EX/MEM
- `mem_req_o`  out  1  memory request, held until ack
- `mem_we_o`  out  1  1 = write, 0 = read
- `mem_addr_o`  out  ADDR_W  latched address
- `mem_wdata_o`  out  DATA_W  latched store data
- `mem_ack_i`  in  1  memory completion, single-cycle pulse
- `mem_rdata_i`  in  DATA_W  read data, valid with `mem_ack_i`
- `stall_o`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- `rdata_o`  out  DATA_W  last completed load data, to MEM/WB
- `rdata_valid_o`  out  1  one-cycle pulse when `rdata_o` updates
- `misalign_o`  out  1  one-cycle pulse when an access is dropped for misalignment
- `timeout_o`  out  1  one-cycle pulse when an access is aborted by timeout

## Operation
- **Access present.** `acc = start_i & (MemRead_i | MemWrite_i)`. If both request bits are set, the access is a write.
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE, aligned access** (`acc` and `addr_i[1:0]==0`):
  - latch `addr_i`, `wdata_i` and `we = MemWrite_i` into the `mem_*_o` registers;
  - clear the timeout counter;
  - go to ACCESS.
- **IDLE, misaligned access** (`acc` and `addr_i[1:0]!=0`):
  - no memory request, stay in IDLE;
  - pulse `misalign_o` on the next cycle;
  - `stall_o` stays 0 and `rdata_o` is unchanged.
- **ACCESS:**
  - `mem_req_o`=1; addr/we/wdata held stable.
  - On `mem_ack_i`: drop `mem_req_o`; if read, `rdata_o <= mem_rdata_i`; go to DONE.
  - Otherwise the counter increments. When the counter is at TIMEOUT-1 with no ack: drop `mem_req_o`, set `rdata_o <= 0`, go to DONE flagged as timeout.
  - An ack on the final cycle wins over the timeout.
- **DONE:** always returns to IDLE on the next edge. Outputs in DONE:
  - `rdata_valid_o`=1 for a completed read (including a timed-out read);
  - `timeout_o`=1 if aborted.
- **Stall.** `stall_o = ~rst_i & ((state==IDLE & acc & aligned) | state==ACCESS)`. It is combinational, so the pipeline freezes in the same cycle the access appears.
- **DONE does not re-issue.** In DONE `stall_o`=0, so the pipeline advances at the end of DONE. The instruction still visible on the inputs in DONE is not re-issued.
- **start_i deassertion.** Deasserting `start_i` in ACCESS or DONE does not abort the transaction.
- **Unexpected ack.** `mem_ack_i` outside ACCESS is ignored.

## Timing
- **Reset values.** On reset the FSM goes to IDLE and every output reads 0: `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `rdata_o`, `rdata_valid_o`, `misalign_o`, `timeout_o`, `stall_o`. `stall_o` is forced 0 while `rst_i`=1.
- **Reset mid-transaction.** Reset in ACCESS or DONE takes effect at the next edge: request dropped, no `rdata_valid_o`, no `timeout_o`.
- **Access timeline,** with ack arriving L cycles after `mem_req_o` first rises (L=0 means ack in the first ACCESS cycle):
  - cycle 0: IDLE, `stall_o`=1;
  - cycles 1..1+L: ACCESS, `mem_req_o`=1, `stall_o`=1;
  - cycle 2+L: DONE, `stall_o`=0, pulses valid.
  - Total stall cycles: 2+L.
- **Timeout timeline.** ACCESS lasts exactly TIMEOUT cycles, then DONE; stall cycles = 1+TIMEOUT.
- **Back-to-back accesses.** A new access is evaluated in the IDLE cycle after DONE. Minimum spacing is 3 cycles per access.
- **Counter width:** `$clog2(TIMEOUT)`+1 bits, no wrap inside ACCESS.

## Test plan
- **Load, fixed latency.** MemRead_i=1, addr_i=0x10; memory acks at L=2 with 0xCAFEF00D. Expect:
  - `stall_o` high 4 cycles; `mem_req_o` high 3 cycles with `mem_we_o`=0 and `mem_addr_o`=0x10;
  - `rdata_o`=0xCAFEF00D with `rdata_valid_o` pulse in DONE.
- **Store, L=0.** MemWrite_i=1, addr_i=0x20, wdata_i=0x12345678, ack in the first ACCESS cycle. Expect:
  - `mem_we_o`=1, `mem_wdata_o`=0x12345678;
  - 2 stall cycles, no `rdata_valid_o`, `rdata_o` unchanged.
- **Misaligned.** MemRead_i=1, addr_i=0x22. Expect no `mem_req_o`, `stall_o`=0, one `misalign_o` pulse, `rdata_o` unchanged.
- **Timeout.** TIMEOUT=16, read, no ack ever. Expect:
  - `mem_req_o` high exactly 16 cycles, 17 stall cycles;
  - DONE with `timeout_o`=1, `rdata_valid_o`=1, `rdata_o`=0.
  - Repeat with the ack on the 16th cycle: normal completion, no `timeout_o`.
- **Reset mid-access.** Read at L=5; assert `rst_i` on the 3rd ACCESS cycle. Expect all outputs 0 at the next edge, FSM in IDLE, and a later ack ignored.
- **Back-to-back.** Load at 0x0, then store at 0x4 presented in DONE/IDLE. Expect each issued exactly once, the store's `mem_req_o` rising 2 cycles after the load's DONE, and `start_i` dropped during ACCESS not aborting.
